// File: rtl/pmci_axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master among NUM_REQ requesters, one transaction in flight.
// Optional response watchdog enabled by defining PMCI_ARB_TIMEOUT_EN.
module pmci_axil_req_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned AW          = 21,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*AW-1:0]       req_addr,
    input  logic [NUM_REQ*DW-1:0]       req_wdata,
    input  logic [NUM_REQ*(DW/8)-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DW-1:0]               rsp_rdata,
    output logic                        rsp_err,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [AW-1:0]               m_awaddr,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    output logic [DW-1:0]               m_wdata,
    output logic [DW/8-1:0]             m_wstrb,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    input  logic [1:0]                  m_bresp,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [AW-1:0]               m_araddr,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [DW-1:0]               m_rdata,
    input  logic [1:0]                  m_rresp
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic               wr_q, wr_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [SW-1:0]      wstrb_q, wstrb_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               arvalid_q, arvalid_d;
    logic               bready_q, bready_d;
    logic               rready_q, rready_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               any_req;
    logic               hit_hi;
    logic [IW-1:0]      sel_hi, sel_lo, sel;
    logic               tmo_hit;

    assign any_req = |req_valid;

    // Round-robin pick: lowest requester at/above the pointer, else lowest overall.
    always_comb begin
        hit_hi = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                sel_lo = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    hit_hi = 1'b1;
                    sel_hi = IW'(i);
                end
            end
        end
        sel = hit_hi ? sel_hi : sel_lo;
    end

`ifdef PMCI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog counts cycles spent in ADDR/RESP; cleared by every grant.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ADDR) || (state_q == RESP)) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
    end

    assign tmo_hit = ((state_q == ADDR) || (state_q == RESP)) &&
                     (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                bready_d = 1'b1;
                rready_d = 1'b1;
                if (any_req) begin
                    gnt_d              = sel;
                    req_ready_d[sel]   = 1'b1;
                    wr_d               = req_write[sel];
                    addr_d             = req_addr[sel*AW +: AW];
                    wdata_d            = req_wdata[sel*DW +: DW];
                    wstrb_d            = req_wstrb[sel*SW +: SW];
                    bready_d           = 1'b0;
                    rready_d           = 1'b0;
                    state_d            = ADDR;
                end
            end
            ADDR: begin
                if (|req_ready_q) begin
                    // First ADDR cycle launches the address (and data) channels.
                    awvalid_d = wr_q;
                    wvalid_d  = wr_q;
                    arvalid_d = ~wr_q;
                end else begin
                    awvalid_d = awvalid_q & ~m_awready;
                    wvalid_d  = wvalid_q & ~m_wready;
                    arvalid_d = arvalid_q & ~m_arready;
                    if (!awvalid_d && !wvalid_d && !arvalid_d) begin
                        bready_d = wr_q;
                        rready_d = ~wr_q;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                bready_d = bready_q;
                rready_d = rready_q;
                if (wr_q ? (m_bvalid && bready_q) : (m_rvalid && rready_q)) begin
                    rsp_rdata_d        = wr_q ? '0 : m_rdata;
                    rsp_err_d          = wr_q ? m_bresp[1] : m_rresp[1];
                    rsp_valid_d[gnt_q] = 1'b1;
                    bready_d           = 1'b0;
                    rready_d           = 1'b0;
                    state_d            = DONE;
                end
            end
            DONE: begin
                ptr_d    = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);
                bready_d = 1'b1;
                rready_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog expiry abandons the transaction and reports an error.
        if (tmo_hit && (state_d != DONE)) begin
            awvalid_d          = 1'b0;
            wvalid_d           = 1'b0;
            arvalid_d          = 1'b0;
            bready_d           = 1'b0;
            rready_d           = 1'b0;
            rsp_rdata_d        = '1;
            rsp_err_d          = 1'b1;
            rsp_valid_d        = '0;
            rsp_valid_d[gnt_q] = 1'b1;
            state_d            = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b1;
            rready_q    <= 1'b1;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_awvalid = awvalid_q;
    assign m_awaddr  = addr_q;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_araddr  = addr_q;
    assign m_rready  = rready_q;

    // Only resp[1] distinguishes error from okay.
    logic unused_ok;
    assign unused_ok = ^{m_bresp[0], m_rresp[0], 32'(TIMEOUT_CYC)};

endmodule

// File: tb/tb_pmci_axil_req_arbiter.sv
// Directed bench for pmci_axil_req_arbiter: latency, wait states, round-robin, split handshakes, reset.
module tb_pmci_axil_req_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned AW      = 21;
    localparam int unsigned DW      = 32;
    localparam int unsigned SW      = DW / 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*AW-1:0]     req_addr;
    logic [NUM_REQ*DW-1:0]     req_wdata;
    logic [NUM_REQ*SW-1:0]     req_wstrb;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DW-1:0]             rsp_rdata;
    logic                      rsp_err;
    logic                      m_awvalid, m_awready;
    logic [AW-1:0]             m_awaddr;
    logic                      m_wvalid, m_wready;
    logic [DW-1:0]             m_wdata;
    logic [SW-1:0]             m_wstrb;
    logic                      m_bvalid, m_bready;
    logic [1:0]                m_bresp;
    logic                      m_arvalid, m_arready;
    logic [AW-1:0]             m_araddr;
    logic                      m_rvalid, m_rready;
    logic [DW-1:0]             m_rdata;
    logic [1:0]                m_rresp;

    int n_cmp = 0;
    int n_err = 0;

    pmci_axil_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .AW         (AW),
        .DW         (DW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bresp   (m_bresp),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (req_ready == '0 && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rsp(input int lim, output bit extra_grant);
        int n = 0;
        extra_grant = 1'b0;
        while (rsp_valid == '0 && n < lim) begin
            tick();
            if (req_ready != '0) extra_grant = 1'b1;
            n++;
        end
    endtask

    task automatic zero_wait_slave();
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid  = 1'b1; m_bresp  = 2'b00;
        m_rvalid  = 1'b1; m_rresp  = 2'b00; m_rdata = '0;
    endtask

    initial begin
        bit extra;
        logic [NUM_REQ-1:0] exp_g;

        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        zero_wait_slave();
        tick();
        tick();
        chk("rst_awvalid", {m_awvalid, m_wvalid, m_arvalid}, 3'b000);
        chk("rst_readies", {m_bready, m_rready}, 2'b11);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        rst = 1'b0;
        tick();

        // Zero-wait write from requester 0.
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[0*AW +: AW]  = 21'h00400;
        req_wdata[0*DW +: DW] = 32'hA5A5_1234;
        req_wstrb[0*SW +: SW] = 4'hF;
        tick();
        chk("w0_req_ready_T", req_ready, 2'b01);
        chk("w0_no_valid_T", {m_awvalid, m_wvalid}, 2'b00);
        req_valid = '0;
        tick();
        chk("w0_valids_T1", {m_awvalid, m_wvalid, m_arvalid}, 3'b110);
        chk("w0_awaddr", m_awaddr, 21'h00400);
        chk("w0_wdata", m_wdata, 32'hA5A5_1234);
        chk("w0_wstrb", m_wstrb, 4'hF);
        tick();
        chk("w0_resp_T2", {m_awvalid, m_wvalid, m_bready, rsp_valid}, 5'b00100);
        tick();
        chk("w0_rsp_valid_T3", rsp_valid, 2'b01);
        chk("w0_rsp_err", rsp_err, 1'b0);
        chk("w0_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        chk("w0_rsp_pulse", rsp_valid, 2'b00);

        // Read from requester 1 with five R wait cycles and SLVERR.
        m_rvalid = 1'b0;
        req_valid = 2'b10; req_write = 2'b00;
        req_addr[1*AW +: AW] = 21'h00008;
        wait_ready(10);
        chk("r1_req_ready", req_ready, 2'b10);
        req_valid = '0;
        tick();
        chk("r1_arvalid", {m_arvalid, m_awvalid, m_wvalid}, 3'b100);
        chk("r1_araddr", m_araddr, 21'h00008);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("r1_wait", {m_arvalid, m_rready, rsp_valid}, 4'b0100);
            tick();
        end
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001; m_rresp = 2'b10;
        tick();
        chk("r1_rsp_valid", rsp_valid, 2'b10);
        chk("r1_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("r1_rsp_err", rsp_err, 1'b1);
        zero_wait_slave();
        tick();

        // Both requesters continuously requesting: strict alternation.
        req_valid = 2'b11; req_write = 2'b00;
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_ready(20);
            chk("rr_grant", req_ready, exp_g);
            wait_rsp(20, extra);
            chk("rr_rsp", rsp_valid, exp_g);
            chk("rr_single_grant", extra, 1'b0);
        end
        req_valid = '0;
        tick();
        tick();

        // W accepted three cycles before AW.
        m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b0;
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[0*AW +: AW]  = 21'h01234;
        req_wdata[0*DW +: DW] = 32'hDEAD_BEEF;
        req_wstrb[0*SW +: SW] = 4'h3;
        wait_ready(10);
        chk("aw_late_grant", req_ready, 2'b01);
        req_valid = '0;
        tick();
        chk("aw_late_T1", {m_awvalid, m_wvalid}, 2'b11);
        tick();
        chk("aw_late_T2", {m_awvalid, m_wvalid, m_bready}, 3'b100);
        chk("aw_late_addr2", m_awaddr, 21'h01234);
        tick();
        chk("aw_late_T3", {m_awvalid, m_wvalid}, 2'b10);
        chk("aw_late_addr3", m_awaddr, 21'h01234);
        tick();
        chk("aw_late_T4", {m_awvalid, m_wvalid}, 2'b10);
        m_awready = 1'b1;
        tick();
        chk("aw_late_resp", {m_awvalid, m_wvalid, m_bready, rsp_valid}, 5'b00100);
        m_bvalid = 1'b1; m_bresp = 2'b00;
        tick();
        chk("aw_late_rsp", {rsp_valid, rsp_err}, 3'b010);
        m_bvalid = 1'b0;
        tick();

        // AW accepted three cycles before W, DECERR response.
        m_awready = 1'b1; m_wready = 1'b0;
        req_valid = 2'b10; req_write = 2'b10;
        req_addr[1*AW +: AW]  = 21'h00ABC;
        req_wdata[1*DW +: DW] = 32'h1111_2222;
        req_wstrb[1*SW +: SW] = 4'hC;
        wait_ready(10);
        chk("w_late_grant", req_ready, 2'b10);
        req_valid = '0;
        tick();
        chk("w_late_T1", {m_awvalid, m_wvalid}, 2'b11);
        tick();
        chk("w_late_T2", {m_awvalid, m_wvalid}, 2'b01);
        chk("w_late_data2", {m_wdata, m_wstrb}, {32'h1111_2222, 4'hC});
        tick();
        chk("w_late_T3", {m_awvalid, m_wvalid}, 2'b01);
        tick();
        chk("w_late_data4", {m_wvalid, m_wdata, m_wstrb}, {1'b1, 32'h1111_2222, 4'hC});
        m_wready = 1'b1;
        tick();
        chk("w_late_resp", {m_awvalid, m_wvalid, m_bready}, 3'b001);
        m_bvalid = 1'b1; m_bresp = 2'b11;
        tick();
        chk("w_late_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b1, 32'h0});
        zero_wait_slave();
        tick();

        // Advance pointer to 1, then reset with requester 1 stuck in RESP.
        req_valid = 2'b01; req_write = 2'b01;
        wait_ready(10);
        chk("pre_rst_grant0", req_ready, 2'b01);
        req_valid = '0;
        wait_rsp(10, extra);
        chk("pre_rst_rsp0", rsp_valid, 2'b01);
        m_bvalid = 1'b0;
        tick();
        req_valid = 2'b10; req_write = 2'b10;
        wait_ready(10);
        chk("pre_rst_grant1", req_ready, 2'b10);
        req_valid = '0;
        tick();
        tick();
        chk("pre_rst_in_resp", {m_awvalid, m_wvalid, m_bready, m_rready}, 4'b0010);
        rst = 1'b1;
        #1;
        chk("rst_mid_valids", {m_awvalid, m_wvalid, m_arvalid, req_ready, rsp_valid}, 7'b0);
        chk("rst_mid_readies", {m_bready, m_rready}, 2'b11);
        tick();
        rst = 1'b0;
        zero_wait_slave();
        req_valid = 2'b11; req_write = 2'b00;
        wait_ready(10);
        chk("post_rst_grant", req_ready, 2'b01);
        req_valid = '0;
        wait_rsp(10, extra);
        chk("post_rst_rsp", rsp_valid, 2'b01);
        tick();

`ifdef PMCI_ARB_TIMEOUT_EN
        // Slave never accepts AR: watchdog fires.
        begin
            int n_ar;
            n_ar = 0;
            m_arready = 1'b0;
            req_valid = 2'b10; req_write = 2'b00;
            wait_ready(10);
            chk("tmo_grant", req_ready, 2'b10);
            req_valid = '0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (m_arvalid) n_ar++;
                else break;
            end
            chk("tmo_ar_cycles", n_ar, 15);
            chk("tmo_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b1, 32'hFFFF_FFFF});
            zero_wait_slave();
            tick();
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
